// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter that shares one SRAM-style slave between an instruction
// fetch port (i_*) and a data load/store port (d_*). One transaction is in
// flight at a time. It walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// When both ports request together, the port that did not win last time gets
// the slave (round-robin).
//
// Parameters
//   TIMEOUT   maximum number of WAIT cycles before the transaction is aborted
//             with an error (legal range 2..255).
//
// Ports
//   Hclock    clock; all logic runs on its rising edge.
//   Hreset    synchronous active-high reset.
//   i_req     instruction fetch request (level, held until i_done).
//   i_addr    fetch byte address.
//   i_rdata   last fetched word.
//   i_done    one-cycle completion pulse for the fetch port.
//   i_err     fetch timed out (valid only with i_done).
//   d_req     data request (level, held until d_done).
//   d_write   1 = store, 0 = load.
//   d_size    1 = word, 0 = byte.
//   d_addr    data byte address.
//   d_wdata   store data.
//   d_rdata   last load result.
//   d_done    one-cycle completion pulse for the data port.
//   d_err     data access timed out (valid only with d_done).
//   s_select  slave select, high for the single ISSUE cycle.
//   s_ready   command strobe, high for the single ISSUE cycle.
//   s_write   latched command direction.
//   s_size    latched command size.
//   s_addr    latched command address.
//   s_wdata   latched store data.
//   s_rdata   read data from the slave.
//   s_hready  slave not busy; completes the access while in WAIT.
//   busy      high whenever the arbiter is not IDLE.
//   owner     last granted port: 0 = instruction, 1 = data.
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        Hclock,
  input  logic        Hreset,

  input  logic        i_req,
  input  logic [21:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,

  input  logic        d_req,
  input  logic        d_write,
  input  logic        d_size,
  input  logic [21:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,

  output logic        s_select,
  output logic        s_ready,
  output logic        s_write,
  output logic        s_size,
  output logic [21:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_hready,

  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter value at which a still-stalled WAIT cycle gives up. The counter
  // is 0 in the first WAIT cycle, so TIMEOUT-1 is the TIMEOUT-th WAIT cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q,   state_d;
  logic        owner_q,   owner_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic        err_q,     err_d;
  logic        s_write_q, s_write_d;
  logic        s_size_q,  s_size_d;
  logic [21:0] s_addr_q,  s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // Data wins when it is the only requester, or when both request and the
  // instruction port was the previous owner.
  logic grant_data;
  assign grant_data = d_req & (~i_req | ~owner_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Hclock) begin
    if (Hreset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      s_write_q <= 1'b0;
      s_size_q  <= 1'b0;
      s_addr_q  <= 22'd0;
      s_wdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      s_write_q <= s_write_d;
      s_size_q  <= s_size_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    s_write_d = s_write_q;
    s_size_d  = s_size_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // A stale error from the previous transaction must not leak into the
        // next DONE cycle.
        err_d = 1'b0;
        if (i_req || d_req) begin
          owner_d = grant_data;
          if (grant_data) begin
            s_write_d = d_write;
            s_size_d  = d_size;
            s_addr_d  = d_addr;
            s_wdata_d = d_wdata;
          end else begin
            // Fetches are always word reads with no store data.
            s_write_d = 1'b0;
            s_size_d  = 1'b1;
            s_addr_d  = i_addr;
            s_wdata_d = 32'd0;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (s_hready) begin
          if (!s_write_q) begin
            if (owner_q) begin
              d_rdata_d = s_rdata;
            end else begin
              i_rdata_d = s_rdata;
            end
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registers, so none depend on inputs directly)
  // ---------------------------------------------------------------------------
  assign s_select = (state_q == ST_ISSUE);
  assign s_ready  = (state_q == ST_ISSUE);
  assign s_write  = s_write_q;
  assign s_size   = s_size_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;

  assign i_done   = (state_q == ST_DONE) && !owner_q;
  assign d_done   = (state_q == ST_DONE) &&  owner_q;
  assign i_err    = i_done & err_q;
  assign d_err    = d_done & err_q;

  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with hand-computed expected values. Inputs
// are driven 1 ns after each rising edge, and outputs are checked at the same
// point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  logic        Hclock;
  logic        Hreset;
  logic        i_req;
  logic [21:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;
  logic        d_req;
  logic        d_write;
  logic        d_size;
  logic [21:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        s_select;
  logic        s_ready;
  logic        s_write;
  logic        s_size;
  logic [21:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_hready;
  logic        busy;
  logic        owner;

  int total_cnt;
  int bad_cnt;

  sram_arbiter #(.TIMEOUT(15)) dut (
    .Hclock   (Hclock),
    .Hreset   (Hreset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_write  (d_write),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .d_err    (d_err),
    .s_select (s_select),
    .s_ready  (s_ready),
    .s_write  (s_write),
    .s_size   (s_size),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_hready (s_hready),
    .busy     (busy),
    .owner    (owner)
  );

  initial Hclock = 1'b0;
  always #5 Hclock = ~Hclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Hclock);
    #1;
  endtask

  task automatic do_reset();
    Hreset = 1'b1;
    tick();
    tick();
    Hreset = 1'b0;
  endtask

  logic [31:0] rr_data [4];
  logic        rr_own  [4];
  int          waits;

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    i_req = 0; i_addr = 0; d_req = 0; d_write = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; s_rdata = 0; s_hready = 0;
    Hreset = 1'b1;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_owner",  32'(owner), 32'd0);
    chk("rst_select", 32'(s_select), 32'd0);
    chk("rst_saddr",  32'(s_addr), 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    chk("rst_done",   32'({i_done, d_done}), 32'd0);

    // ---------------- data word read ----------------
    d_req = 1; d_write = 0; d_size = 1; d_addr = 22'h000010;
    s_hready = 1; s_rdata = 32'hDEADBEEF;
    tick();  // T+1 ISSUE
    chk("rd_select", 32'(s_select), 32'd1);
    chk("rd_ready",  32'(s_ready), 32'd1);
    chk("rd_saddr",  32'(s_addr), 32'h10);
    chk("rd_owner",  32'(owner), 32'd1);
    tick();  // T+2 WAIT
    chk("rd_wait_sel", 32'(s_select), 32'd0);
    chk("rd_wait_done", 32'(d_done), 32'd0);
    tick();  // T+3 DONE
    chk("rd_done",  32'(d_done), 32'd1);
    chk("rd_err",   32'(d_err), 32'd0);
    chk("rd_data",  d_rdata, 32'hDEADBEEF);
    chk("rd_idone", 32'(i_done), 32'd0);
    d_req = 0;
    tick();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_idle_done", 32'(d_done), 32'd0);

    // ---------------- word write, two stalled WAIT cycles ----------------
    d_req = 1; d_write = 1; d_size = 1; d_addr = 22'h000020; d_wdata = 32'h12345678;
    s_hready = 0; s_rdata = 32'h55555555;
    tick();  // T+1 ISSUE
    chk("wr_select", 32'(s_select), 32'd1);
    chk("wr_swrite", 32'(s_write), 32'd1);
    chk("wr_ssize",  32'(s_size), 32'd1);
    tick();  // T+2 WAIT, stalled
    chk("wr_wdata_w1", s_wdata, 32'h12345678);
    tick();  // T+3 WAIT, stalled
    chk("wr_wdata_w2", s_wdata, 32'h12345678);
    chk("wr_nodone",   32'(d_done), 32'd0);
    tick();  // T+4 WAIT, slave ready
    chk("wr_nodone2",  32'(d_done), 32'd0);
    s_hready = 1;
    tick();  // T+5 DONE
    chk("wr_done",   32'(d_done), 32'd1);
    chk("wr_err",    32'(d_err), 32'd0);
    chk("wr_rdata",  d_rdata, 32'hDEADBEEF);
    chk("wr_wdata_d", s_wdata, 32'h12345678);
    d_req = 0;
    tick();

    // ---------------- round-robin, both requests held from reset ----------------
    i_req = 1; i_addr = 22'h000100;
    d_req = 1; d_write = 0; d_size = 1; d_addr = 22'h000200;
    s_hready = 1;
    do_reset();
    rr_own[0] = 1; rr_own[1] = 0; rr_own[2] = 1; rr_own[3] = 0;
    rr_data[0] = 32'hA0000001; rr_data[1] = 32'hA0000002;
    rr_data[2] = 32'hA0000003; rr_data[3] = 32'hA0000004;
    for (int g = 0; g < 4; g++) begin
      s_rdata = rr_data[g];
      tick();  // ISSUE
      chk($sformatf("rr%0d_owner", g), 32'(owner), 32'(rr_own[g]));
      chk($sformatf("rr%0d_saddr", g), 32'(s_addr), rr_own[g] ? 32'h200 : 32'h100);
      tick();  // WAIT
      tick();  // DONE
      chk($sformatf("rr%0d_done", g), 32'({i_done, d_done}), rr_own[g] ? 32'd1 : 32'd2);
      if (rr_own[g]) chk($sformatf("rr%0d_drdata", g), d_rdata, rr_data[g]);
      else           chk($sformatf("rr%0d_irdata", g), i_rdata, rr_data[g]);
      if (g == 3) begin
        i_req = 0;
        d_req = 0;
      end
      tick();  // IDLE
      chk($sformatf("rr%0d_pulse", g), 32'({i_done, d_done}), 32'd0);
    end

    // ---------------- timeout on a fetch ----------------
    i_req = 1; i_addr = 22'h000300; s_hready = 0; s_rdata = 32'h77777777;
    tick();  // ISSUE
    chk("to_select", 32'(s_select), 32'd1);
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (i_done) break;
      waits++;
    end
    chk("to_waits",  32'(waits), 32'd15);
    chk("to_done",   32'(i_done), 32'd1);
    chk("to_err",    32'(i_err), 32'd1);
    chk("to_rdata",  i_rdata, 32'hA0000004);
    i_req = 0;
    tick();
    chk("to_err_clr", 32'(i_err), 32'd0);
    i_req = 1; s_hready = 1; s_rdata = 32'hCAFEF00D;
    tick();  // ISSUE
    tick();  // WAIT
    tick();  // DONE
    chk("to2_done",  32'(i_done), 32'd1);
    chk("to2_err",   32'(i_err), 32'd0);
    chk("to2_rdata", i_rdata, 32'hCAFEF00D);
    i_req = 0;
    tick();

    // ---------------- reset during WAIT ----------------
    d_req = 1; d_write = 0; d_size = 1; d_addr = 22'h000040;
    s_hready = 0; s_rdata = 32'h0BADF00D;
    tick();  // ISSUE
    tick();  // WAIT
    chk("rw_busy_wait", 32'(busy), 32'd1);
    Hreset = 1;
    tick();  // reset taken
    chk("rw_busy",   32'(busy), 32'd0);
    chk("rw_select", 32'(s_select), 32'd0);
    chk("rw_done",   32'(d_done), 32'd0);
    chk("rw_drdata", d_rdata, 32'd0);
    Hreset = 0;
    s_hready = 1;
    tick();  // ISSUE of the new request
    chk("rw_new_select", 32'(s_select), 32'd1);
    chk("rw_new_saddr",  32'(s_addr), 32'h40);
    tick();  // WAIT
    tick();  // DONE
    chk("rw_new_done",  32'(d_done), 32'd1);
    chk("rw_new_rdata", d_rdata, 32'h0BADF00D);
    d_req = 0;
    tick();

    // ---------------- byte write at an unaligned address ----------------
    d_req = 1; d_write = 1; d_size = 0; d_addr = 22'h000003; d_wdata = 32'h000000AB;
    s_hready = 0; s_rdata = 32'h99999999;
    tick();  // ISSUE
    chk("bw_ssize", 32'(s_size), 32'd0);
    chk("bw_saddr", 32'(s_addr), 32'h3);
    chk("bw_wdata", s_wdata, 32'hAB);
    tick();  // WAIT
    tick();  // WAIT
    chk("bw_wdata_w", s_wdata, 32'hAB);
    chk("bw_saddr_w", 32'(s_addr), 32'h3);
    chk("bw_nodone",  32'(d_done), 32'd0);
    s_hready = 1;
    tick();  // DONE
    chk("bw_done",   32'(d_done), 32'd1);
    chk("bw_rdata",  d_rdata, 32'h0BADF00D);
    chk("bw_ssize_d", 32'(s_size), 32'd0);
    d_req = 0;
    tick();
    chk("bw_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, the maximum number of WAIT cycles before a transaction is aborted; legal range 2..255.
REQ-002 The arbiter SHALL have a single clock: Hclock  in  1  clock; all logic is on the rising edge.
REQ-003 Hreset  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  instruction-fetch request, level; i_addr  in  22  fetch byte address.
REQ-005 i_rdata  out  32  fetched word; i_done  out  1  one-cycle completion pulse; i_err  out  1  timeout flag, valid with i_done.
REQ-006 d_req  in  1  data request, level; d_write  in  1  1=write; d_size  in  1  1=word, 0=byte; d_addr  in  22; d_wdata  in  32.
REQ-007 d_rdata  out  32  load result; d_done  out  1  completion pulse; d_err  out  1  timeout flag, valid with d_done.
REQ-008 Slave side: s_select, s_ready, s_write, s_size  out  1 each; s_addr  out  22; s_wdata  out  32.
REQ-009 Slave side inputs: s_rdata  in  32; s_hready  in  1  slave not busy.
REQ-010 busy  out  1  high in any state other than IDLE; owner  out  1  0=instruction, 1=data; owner is the last granted port.

Function
REQ-011 The arbiter SHALL implement the state machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-012 IDLE: if any req is high, the arbiter SHALL pick a winner, latch that port's command into s_write/s_size/s_addr/s_wdata, set owner, and go to ISSUE; otherwise it stays in IDLE.
REQ-013 Instruction command SHALL be latched as s_write=0, s_size=1, s_addr=i_addr, s_wdata=0.
REQ-014 Data command SHALL be latched as d_write/d_size/d_addr/d_wdata.
REQ-015 When only one port requests, that port SHALL win.
REQ-016 When both ports request, the port not equal to owner SHALL win (round-robin).
REQ-017 ISSUE: s_select=1 and s_ready=1 for exactly one cycle; the wait counter SHALL clear to 0; next state is WAIT.
REQ-018 In all states other than ISSUE, s_select=0 and s_ready=0; s_write/s_size/s_addr/s_wdata SHALL hold the latched command.
REQ-019 WAIT with s_hready=1: the transaction completes and next state is DONE; on a read, s_rdata SHALL be captured into the owner's rdata register.
REQ-020 On a write, rdata registers SHALL remain unchanged.
REQ-021 WAIT with s_hready=0: the counter increments (8-bit, saturating).
REQ-022 If the counter reaches TIMEOUT-1 while s_hready=0, the arbiter SHALL set the err flag, leave rdata unchanged, and go to DONE.
REQ-023 DONE: the owner's done SHALL be high for exactly this one cycle, err is high only on timeout, req inputs are ignored, and next state is IDLE.
REQ-024 err SHALL be low whenever the corresponding done is low.
REQ-025 Latency, with req sampled in IDLE at cycle T: ISSUE T+1, first WAIT T+2, done at T+3 plus the number of s_hready=0 cycles in WAIT.
REQ-026 A requester SHALL hold req and its command stable until it sees done; a req still high in the IDLE cycle after DONE is a new transaction.
REQ-027 The arbiter SHALL NOT check alignment; d_addr[1:0] and i_addr[1:0] pass to s_addr unchanged.
REQ-028 Only one transaction SHALL be outstanding at a time; no pipelining.

Reset
REQ-029 On Hreset=1 at a clock edge: state=IDLE, owner=0, counter=0, and all s_* outputs, rdata registers, done, err and busy SHALL be 0.
REQ-030 Because owner=0 after reset, the data port SHALL win the first simultaneous request.
REQ-031 Reset during ISSUE/WAIT/DONE SHALL abort the transaction with no done pulse; the next cycle has s_select=0.

Verification
REQ-032 Data read: reset, then d_req=1, d_write=0, d_size=1, d_addr=0x000010; slave returns s_hready=1, s_rdata=0xDEADBEEF on first WAIT -> s_select=1 at T+1, d_done=1 at T+3, d_rdata=0xDEADBEEF, d_err=0.
REQ-033 Word write: slave holds s_hready low for 2 WAIT cycles -> s_write=1, s_size=1, s_wdata stable through WAIT, d_done at T+5, d_rdata unchanged.
REQ-034 Round-robin: i_req and d_req both held high from reset -> grant order is data, instr, data, instr; owner alternates; each done is a single pulse.
REQ-035 Timeout: TIMEOUT=15, s_hready stuck 0 after ISSUE -> exactly 15 WAIT cycles, then i_done=1 with i_err=1 and i_rdata unchanged; next fetch completes with i_err=0.
REQ-036 Reset mid-WAIT: Hreset=1 for one cycle in WAIT -> no done pulse, busy=0 the cycle after reset, and a new request after reset issues normally.
REQ-037 Byte write with d_addr=0x000003, d_size=0, d_wdata=0x000000AB -> s_size=0, s_addr=0x000003, s_wdata=0x000000AB stable throughout, d_done once s_hready rises.
